barrel_shifter_pipe: RTL

//  Parametrised, pipelined barrel shifter/rotator. Four modes: logical left, logical right,

---
 rtl/barrel_shifter_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// barrel_shifter_pipe: pipelined SLL/SRL/SRA/ROL shifter, one 2^k stage per
// register slice, valid/ready on both sides. Optional macro: BARREL_CARRY_EN.
// Rev 1.0
// ============================================================================
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam logic [1:0] c_op_sll = 2'b00;
  localparam logic [1:0] c_op_srl = 2'b01;
  localparam logic [1:0] c_op_sra = 2'b10;
  localparam logic [1:0] c_op_rol = 2'b11;

  // Element k feeds stage k; element k+1 is stage k's register output.
  logic [WIDTH-1:0] chain_data [SHW+1];
  logic [SHW-1:0]   chain_amt  [SHW];
  logic [1:0]       chain_op   [SHW];
  logic [SHW:0]     chain_valid;
  logic [SHW:0]     load;

  assign chain_data[0]  = in_data;
  assign chain_amt[0]   = in_amt;
  assign chain_op[0]    = in_op;
  assign chain_valid[0] = in_valid;

  // A stage loads when empty or when its successor loads; only out_ready and
  // the stage valids feed this, never in_valid.
  always_comb begin
    load      = '0;
    load[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      load[k] = !chain_valid[k+1] || load[k+1];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = chain_valid[SHW];
  assign out_data  = chain_data[SHW];

`ifdef BARREL_CARRY_EN
  logic [SHW:0] chain_carry;
  assign chain_carry[0] = 1'b0;
  assign out_carry      = chain_carry[SHW];
`else
  assign out_carry = 1'b0;
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int c_sh = 1 << k;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
      shifted = chain_data[k];
      if (chain_amt[k][k]) begin
        case (chain_op[k])
          c_op_sll: shifted = chain_data[k] << c_sh;
          c_op_srl: shifted = chain_data[k] >> c_sh;
          c_op_sra: shifted = $signed(chain_data[k]) >>> c_sh;
          c_op_rol: shifted = (chain_data[k] << c_sh) | (chain_data[k] >> (WIDTH - c_sh));
          default:  shifted = chain_data[k];
        endcase
      end
    end

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load[k]) begin
        valid_d = chain_valid[k];
        data_d  = shifted;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign chain_valid[k+1] = valid_q;
    assign chain_data[k+1]  = data_q;

    // Amount and op have no consumer past the final stage.
    if (k < SHW - 1) begin : g_fwd
      logic [SHW-1:0] amt_d;
      logic [SHW-1:0] amt_q;
      logic [1:0]     op_d;
      logic [1:0]     op_q;

      always_comb begin
        amt_d = amt_q;
        op_d  = op_q;
        if (load[k]) begin
          amt_d = chain_amt[k];
          op_d  = chain_op[k];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          amt_q <= '0;
          op_q  <= '0;
        end else begin
          amt_q <= amt_d;
          op_q  <= op_d;
        end
      end

      assign chain_amt[k+1] = amt_q;
      assign chain_op[k+1]  = op_q;
    end

`ifdef BARREL_CARRY_EN
    logic cout;
    logic carry_d;
    logic carry_q;

    // Each active stage overwrites the carry, so the last nonzero stage wins.
    always_comb begin
      cout = chain_carry[k];
      if (chain_amt[k][k]) begin
        case (chain_op[k])
          c_op_sll: cout = chain_data[k][WIDTH-c_sh];
          c_op_srl: cout = chain_data[k][c_sh-1];
          c_op_sra: cout = chain_data[k][c_sh-1];
          default:  cout = 1'b0;
        endcase
      end
    end

    always_comb begin
      carry_d = carry_q;
      if (load[k]) begin
        carry_d = cout;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        carry_q <= 1'b0;
      end else begin
        carry_q <= carry_d;
      end
    end

    assign chain_carry[k+1] = carry_q;
`endif
  end

endmodule
`default_nettype wire
